// File: rtl/cpu_rf_reader_pkg.sv
// Register-file shared types and constants for the AsteRISC read stage.
// Contents: register count, address/data/busy-vector typedefs.
// Optional build macro used by the importing files: RF_BYPASS_EN.
package pck_regfile;

    localparam int unsigned rf_nb_regs = 32;
    localparam int unsigned rf_addr_w  = 5;
    localparam int unsigned rf_data_w  = 32;

    typedef logic [rf_addr_w-1:0]  rf_addr_t;
    typedef logic [rf_data_w-1:0]  rf_data_t;
    typedef logic [rf_nb_regs-1:0] rf_busy_t;

endpackage

// File: rtl/cpu_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   i_clk, i_rst           clock, synchronous active-low reset
//   i_accept               read request accepted this cycle
//   i_rd_claim, i_rd_addr  accepted instruction will write i_rd_addr
//   i_flush                drop every pending claim
//   i_rf_wr_en/_addr       write-back clears the matching busy bit
//   i_rs*_addr, i_rs*_used source operands of the current request
//   o_busy                 registered busy vector (bit 0 always 0)
//   o_rs*_stall_c          combinational per-source stall flags
// Macro RF_BYPASS_EN: a source written back this cycle is not considered busy.
module cpu_rf_scoreboard
    import pck_regfile::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_accept,
    input  logic     i_rd_claim,
    input  rf_addr_t i_rd_addr,
    input  logic     i_flush,
    input  logic     i_rf_wr_en,
    input  rf_addr_t i_rf_wr_addr,
    input  rf_addr_t i_rs1_addr,
    input  rf_addr_t i_rs2_addr,
    input  logic     i_rs1_used,
    input  logic     i_rs2_used,
    output rf_busy_t o_busy,
    output logic     o_rs1_stall_c,
    output logic     o_rs2_stall_c
);

    logic     wr_clear_c;
    rf_busy_t busy_nxt;

    assign wr_clear_c = i_rf_wr_en && (i_rf_wr_addr != '0);

    // Per-source stall; x0 and unused sources never stall.
    always_comb begin
        o_rs1_stall_c = i_rs1_used && (i_rs1_addr != '0) && o_busy[i_rs1_addr];
        o_rs2_stall_c = i_rs2_used && (i_rs2_addr != '0) && o_busy[i_rs2_addr];
`ifdef RF_BYPASS_EN
        if (wr_clear_c && (i_rf_wr_addr == i_rs1_addr)) o_rs1_stall_c = 1'b0;
        if (wr_clear_c && (i_rf_wr_addr == i_rs2_addr)) o_rs2_stall_c = 1'b0;
`endif
    end

    // Clear before set so a same-index claim (younger) wins.
    always_comb begin
        busy_nxt = o_busy;
        if (i_flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_clear_c) busy_nxt[i_rf_wr_addr] = 1'b0;
            if (i_accept && i_rd_claim && (i_rd_addr != '0)) busy_nxt[i_rd_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) o_busy <= '0;
        else        o_busy <= busy_nxt;
    end

endmodule

// File: rtl/cpu_rf_reader.sv
// Register-file read stage: 32x32 storage, scoreboard-based operand stall,
// one-cycle registered operand read.
// Parameter p_rf_rst: 1 = storage cleared on reset, 0 = only x0 reads as zero.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-low reset
//   i_rd_valid / o_rd_ready        request handshake (ready is combinational)
//   i_rs1/2_addr, i_rs1/2_used     source operands
//   i_rd_claim, i_rd_addr          destination to mark pending on accept
//   i_flush                        drop pending claims and block accept
//   i_rf_wr_en/_addr/_data         write-back port
//   o_rs1/2_data, o_rs_valid       registered operands and valid pulse
//   o_sb_busy                      scoreboard busy vector
// Macro RF_BYPASS_EN: forward write-back data to a request accepted in the same cycle.
module cpu_rf_reader
    import pck_regfile::*;
#(
    parameter bit p_rf_rst = 1'b0
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_rd_valid,
    output logic     o_rd_ready,
    input  rf_addr_t i_rs1_addr,
    input  rf_addr_t i_rs2_addr,
    input  logic     i_rs1_used,
    input  logic     i_rs2_used,
    input  logic     i_rd_claim,
    input  rf_addr_t i_rd_addr,
    input  logic     i_flush,
    input  logic     i_rf_wr_en,
    input  rf_addr_t i_rf_wr_addr,
    input  rf_data_t i_rf_wr_data,
    output rf_data_t o_rs1_data,
    output rf_data_t o_rs2_data,
    output logic     o_rs_valid,
    output rf_busy_t o_sb_busy
);

    rf_data_t mem [rf_nb_regs];
    logic     rs1_stall_c;
    logic     rs2_stall_c;
    logic     accept_c;
    logic     wr_en_c;
    rf_data_t rs1_rd_c;
    rf_data_t rs2_rd_c;

    assign o_rd_ready = !i_flush && !rs1_stall_c && !rs2_stall_c;
    assign accept_c   = i_rd_valid && o_rd_ready;
    assign wr_en_c    = i_rf_wr_en && (i_rf_wr_addr != '0);

    cpu_rf_scoreboard u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_accept      (accept_c),
        .i_rd_claim    (i_rd_claim),
        .i_rd_addr     (i_rd_addr),
        .i_flush       (i_flush),
        .i_rf_wr_en    (i_rf_wr_en),
        .i_rf_wr_addr  (i_rf_wr_addr),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_rs1_used    (i_rs1_used),
        .i_rs2_used    (i_rs2_used),
        .o_busy        (o_sb_busy),
        .o_rs1_stall_c (rs1_stall_c),
        .o_rs2_stall_c (rs2_stall_c)
    );

    // Storage; x0 is never written, writes are never blocked by the scoreboard.
    always_ff @(posedge i_clk) begin
        if (!i_rst && p_rf_rst) begin
            for (int unsigned i = 0; i < rf_nb_regs; i++) mem[i] <= '0;
        end else if (wr_en_c) begin
            mem[i_rf_wr_addr] <= i_rf_wr_data;
        end
    end

    // Read mux with x0 forced to zero, plus optional write-back forwarding.
    always_comb begin
        rs1_rd_c = (i_rs1_addr == '0) ? '0 : mem[i_rs1_addr];
        rs2_rd_c = (i_rs2_addr == '0) ? '0 : mem[i_rs2_addr];
`ifdef RF_BYPASS_EN
        if (wr_en_c && (i_rf_wr_addr == i_rs1_addr)) rs1_rd_c = i_rf_wr_data;
        if (wr_en_c && (i_rf_wr_addr == i_rs2_addr)) rs2_rd_c = i_rf_wr_data;
`endif
    end

    // Output registers; data holds between accepts.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_rs_valid <= 1'b0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
        end else begin
            o_rs_valid <= accept_c;
            if (accept_c) begin
                o_rs1_data <= rs1_rd_c;
                o_rs2_data <= rs2_rd_c;
            end
        end
    end

endmodule

// File: doc/cpu_rf_reader.md
# cpu_rf_reader

Register-file read stage for the AsteRISC core: owns the 32×32-bit integer register storage and a pending-write scoreboard. It accepts operand read requests from decode, returns rs1/rs2 data one cycle later, and stalls a request while a source register is still awaiting write-back. Its write port is driven directly by the write-back stage outputs (`o_rf_wr_data` / `o_rf_wr_addr` / `o_rf_wr_en`).

## Interface
- `p_rf_rst`, default 0: 1 = clear all storage on reset; 0 = storage uninitialised, with only x0 guaranteed zero.
- `i_clk`  in  1  global clock
- `i_rst`  in  1  global reset, synchronous, active-low
- `i_rd_valid`  in  1  read request valid
- `o_rd_ready`  out  1  request can be accepted this cycle (combinational)
- `i_rs1_addr`, `i_rs2_addr`  in  5  source register addresses
- `i_rs1_used`, `i_rs2_used`  in  1  source is actually consumed; unused sources never stall
- `i_rd_claim`  in  1  accepted instruction will write `i_rd_addr` later
- `i_rd_addr`  in  5  destination register to mark pending
- `i_flush`  in  1  discard pending claims and in-flight output
- `i_rf_wr_en`  in  1  write enable from write-back
- `i_rf_wr_addr`  in  5  write address from write-back
- `i_rf_wr_data`  in  32  write data from write-back
- `o_rs1_data`, `o_rs2_data`  out  32  registered operand data
- `o_rs_valid`  out  1  operand outputs valid, one-cycle pulse per accepted request
- `o_sb_busy`  out  32  scoreboard bit vector (debug/hazard visibility)

## Operation
- **Accept.** A request is accepted when `i_rd_valid && o_rd_ready`. Downstream has no backpressure.
- **Ready.** `o_rd_ready` is 0 when `i_flush` is high, or when any used source with a nonzero address has its busy bit set and is not being cleared this cycle (see Configuration). Otherwise `o_rd_ready` is 1, independent of `i_rd_valid`.
- **Scoreboard set.** On accept with `i_rd_claim` and `i_rd_addr != 0`, set `busy[i_rd_addr]`.
- **Scoreboard clear.** On `i_rf_wr_en` with a nonzero address, clear `busy[i_rf_wr_addr]`.
- **Set and clear on the same index in the same cycle:** set wins, because the new claim is younger.
- **x0.** Reads of x0 return 0. Writes to x0 are ignored. `busy[0]` is constantly 0.
- **Storage write.** Storage is written on `i_rf_wr_en` whether or not the busy bit is set, and is never blocked.
- **Flush.** `i_flush` clears all busy bits and forces `o_rs_valid` to 0 on the next cycle. A write-back arriving in the same cycle still updates storage.
- **Reset mid-operation.** Reset drops any in-flight output, and all busy bits go to 0.

## Timing
- **Reset values.** `o_rs_valid` = 0, `o_rs1_data` = 0, `o_rs2_data` = 0, `o_sb_busy` = 0. Storage is zeroed only if `p_rf_rst` = 1.
- **Read latency.** Request accepted at cycle N → data and `o_rs_valid` = 1 at N+1. `o_rs_valid` is 0 at N+1 if there was no accept at N.
- **Write visibility.** A write at cycle N is in storage from N+1.
- **Back-to-back accepts.** One accept per cycle is allowed. Output data holds its last value when `o_rs_valid` = 0.
- **Self-dependency.** A request whose rd equals one of its own rs reads the old value. Its own claim takes effect for the next request only.

## Configuration
- **Macro `RF_BYPASS_EN`.**
- **Defined:**
  - A write-back in cycle N with an address matching a used source counts as not busy in cycle N.
  - The accepted request receives `i_rf_wr_data` for that source, forwarded at N+1.
  - Dependent stall is 0 cycles after write-back.
- **Undefined:**
  - A busy source stays stalled through the write-back cycle.
  - The request is accepted at N+1 and reads the value from storage.
  - Dependent stall is one extra cycle.

## Structure
- **`pck_regfile` package:**
  - constant `rf_nb_regs` = 32
  - typedef `rf_addr_t` (`logic [4:0]`)
  - typedef `rf_data_t` (`logic [31:0]`)
  - typedef `rf_busy_t` (`logic [31:0]`)
- **Sub-module `cpu_rf_scoreboard`:**
  - Owns the busy vector with its set/clear/flush logic.
  - Produces per-source stall flags, including the bypass exception under `RF_BYPASS_EN`.
- **Top level (`cpu_rf_reader`):** holds storage, the read mux, the bypass mux, and the output registers.

## Test plan
- Reset, then write x5=0x1234_5678, then read rs1=x5, rs2=x0 → next cycle `o_rs1_data`=0x1234_5678, `o_rs2_data`=0, `o_rs_valid`=1.
- Write x0=0xFFFF_FFFF, then read x0 → 0. Claim rd=x0 → `o_sb_busy`=0.
- Accept with claim rd=x7; next request has rs2=x7 used → `o_rd_ready`=0 until write-back. Write-back x7=0xA5 at cycle N:
  - with `RF_BYPASS_EN`: accepted at N, `o_rs2_data`=0xA5 at N+1;
  - without it: accepted at N+1, data at N+2.
- Same dependency but with `i_rs2_used`=0 → accepted immediately; the stale x7 value is allowed.
- Same cycle: accept with claim rd=x3 and write-back x3 → `busy[3]`=1 afterwards.
- Claims pending on x1 and x2, then assert `i_flush` → `o_sb_busy`=0 next cycle, `o_rs_valid`=0, and a read of x1 is accepted the following cycle.
